// File: rtl/dm_arbiter_pkg.sv
// Shared types and default sizing for the two-master data-memory arbiter.
package dm_arb_pkg;

   localparam int DATA_SIZE      = 32;
   localparam int MEM_SIZE_BIT   = 12;
   localparam int DM_LATENCY_DEF = 3;
   localparam int CNT_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // WAIT is entered with this count; DONE follows once it reaches zero.
   function automatic logic [CNT_W-1:0] wait_load(input int latency);
      return CNT_W'(latency - 2);
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundles both master request channels and the data-memory command/response port.
interface dm_arbiter_if
   import dm_arb_pkg::*;
#(
   parameter int data_size    = DATA_SIZE,
   parameter int mem_size_bit = MEM_SIZE_BIT
);

   logic                    m0_req,   m1_req;
   logic                    m0_read,  m1_read;
   logic                    m0_write, m1_write;
   logic [mem_size_bit-1:0] m0_address, m1_address;
   logic [data_size-1:0]    m0_wdata, m1_wdata;
   logic [data_size-1:0]    m0_rdata, m1_rdata;
   logic                    m0_ack,   m1_ack;

   logic                    DM_enable, DM_read, DM_write;
   logic [mem_size_bit-1:0] DM_address;
   logic [data_size-1:0]    DM_in;
   logic [data_size-1:0]    DM_out;
   logic                    DM_ready;

   modport slave (
      input  m0_req, m0_read, m0_write, m0_address, m0_wdata,
      input  m1_req, m1_read, m1_write, m1_address, m1_wdata,
      output m0_rdata, m0_ack, m1_rdata, m1_ack,
      output DM_enable, DM_read, DM_write, DM_address, DM_in,
      input  DM_out, DM_ready
   );

   modport master (
      output m0_req, m0_read, m0_write, m0_address, m0_wdata,
      output m1_req, m1_read, m1_write, m1_address, m1_wdata,
      input  m0_rdata, m0_ack, m1_rdata, m1_ack,
      input  DM_enable, DM_read, DM_write, DM_address, DM_in,
      output DM_out, DM_ready
   );

endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Two-way round-robin pick: on contention the master not granted last wins.
module dm_rr_pick (
   input  logic [1:0] elig,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |elig;
      grant_id    = 1'b0;
      if (elig == 2'b11) begin
         grant_id = ~last_grant;
      end else if (elig[1]) begin
         grant_id = 1'b1;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates two masters onto a fixed-latency data memory, one transaction at a time.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int data_size    = DATA_SIZE,
   parameter int mem_size_bit = MEM_SIZE_BIT,
   parameter int DM_LATENCY   = DM_LATENCY_DEF
) (
   input logic          clock,
   input logic          reset,
   dm_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(DM_LATENCY);

   state_e                  state_q, state_d;
   logic                    gid_q, gid_d;
   logic                    last_q, last_d;
   logic                    op_read_q, op_read_d;
   logic [mem_size_bit-1:0] addr_q, addr_d;
   logic [data_size-1:0]    wdata_q, wdata_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ack0_q, ack0_d, ack1_q, ack1_d;
   logic [data_size-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic [1:0] elig;
   logic       grant_valid, grant_id;

   // A master is not eligible during its own ack cycle, so a held request is not re-granted twice.
   assign elig[0] = bus.m0_req & (bus.m0_read | bus.m0_write) & ~ack0_q;
   assign elig[1] = bus.m1_req & (bus.m1_read | bus.m1_write) & ~ack1_q;

   dm_rr_pick u_pick (
      .elig        (elig),
      .last_grant  (last_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         gid_q     <= 1'b0;
         last_q    <= 1'b1;
         op_read_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         gid_q     <= gid_d;
         last_q    <= last_d;
         op_read_q <= op_read_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gid_d     = gid_q;
      last_d    = last_q;
      op_read_d = op_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               gid_d   = grant_id;
               last_d  = grant_id;
               state_d = ST_ISSUE;
               if (grant_id) begin
                  op_read_d = bus.m1_read;
                  addr_d    = bus.m1_address;
                  wdata_d   = bus.m1_wdata;
               end else begin
                  op_read_d = bus.m0_read;
                  addr_d    = bus.m0_address;
                  wdata_d   = bus.m0_wdata;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            // Writes complete unconditionally; reads hold here until the memory reports ready.
            if (!op_read_q || bus.DM_ready) begin
               ack0_d  = ~gid_q;
               ack1_d  = gid_q;
               state_d = ST_IDLE;
               if (op_read_q && !gid_q) rdata0_d = bus.DM_out;
               if (op_read_q &&  gid_q) rdata1_d = bus.DM_out;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.DM_enable  = (state_q == ST_ISSUE);
   assign bus.DM_read    = (state_q == ST_ISSUE) &  op_read_q;
   assign bus.DM_write   = (state_q == ST_ISSUE) & ~op_read_q;
   assign bus.DM_address = addr_q;
   assign bus.DM_in      = wdata_q;
   assign bus.m0_ack     = ack0_q;
   assign bus.m1_ack     = ack1_q;
   assign bus.m0_rdata   = rdata0_q;
   assign bus.m1_rdata   = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a simple word-addressed memory model on the DM port.
module tb_dm_arbiter;
   import dm_arb_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int checks    = 0;
   int failures  = 0;
   int issue_cnt = 0;
   int wr_cnt    = 0;
   int ack0_cnt  = 0;
   int ack1_cnt  = 0;
   int both_ack  = 0;

   logic        dm_ready_tb = 1'b1;
   logic        ovr_en      = 1'b0;
   logic [31:0] ovr_val     = '0;
   logic [31:0] mem [0:1023];

   dm_arbiter_if #(.data_size(32), .mem_size_bit(12)) bus ();

   dm_arbiter #(
      .data_size    (32),
      .mem_size_bit (12),
      .DM_LATENCY   (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Memory model: writes land on the command edge, reads are served from the held address.
   always @(posedge clock) begin
      if (bus.DM_enable && bus.DM_write) mem[bus.DM_address[11:2]] <= bus.DM_in;
   end

   assign bus.DM_out   = ovr_en ? ovr_val : mem[bus.DM_address[11:2]];
   assign bus.DM_ready = dm_ready_tb;

   always @(negedge clock) begin
      if (bus.DM_enable) issue_cnt++;
      if (bus.DM_enable && bus.DM_write) wr_cnt++;
      if (bus.m0_ack) ack0_cnt++;
      if (bus.m1_ack) ack1_cnt++;
      if (bus.m0_ack && bus.m1_ack) both_ack++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input int m, input logic req, input logic rd, input logic wr,
                                input logic [11:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         bus.m0_req = req; bus.m0_read = rd; bus.m0_write = wr;
         bus.m0_address = addr; bus.m0_wdata = wdata;
      end else begin
         bus.m1_req = req; bus.m1_read = rd; bus.m1_write = wr;
         bus.m1_address = addr; bus.m1_wdata = wdata;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Returns the number of edges from request to ack, or 0 if the ack never came.
   task automatic runTxn(input int m, input logic rd, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, output int lat);
      lat = 0;
      applyStimulus(m, 1'b1, rd, wr, addr, wdata);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if ((m == 0 && bus.m0_ack) || (m == 1 && bus.m1_ack)) begin
            lat = k;
            break;
         end
      end
      applyStimulus(m, 1'b0, 1'b0, 1'b0, addr, wdata);
      tick();
   endtask

   task automatic tieTest(input logic [11:0] a0, input logic [11:0] a1, output int t0, output int t1);
      t0 = 0;
      t1 = 0;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, a0, 32'h0);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, a1, 32'h0);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.m0_ack && t0 == 0) begin
            t0 = k;
            applyStimulus(0, 1'b0, 1'b0, 1'b0, a0, 32'h0);
         end
         if (bus.m1_ack && t1 == 0) begin
            t1 = k;
            applyStimulus(1, 1'b0, 1'b0, 1'b0, a1, 32'h0);
         end
         if (t0 != 0 && t1 != 0) break;
      end
      applyStimulus(0, 1'b0, 1'b0, 1'b0, a0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, a1, 32'h0);
      tick();
   endtask

   initial begin
      int lat, t0, t1, n, c1, c2, c3;
      int b_issue, b_wr, b_ack0, b_ack1;

      applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
      tick();
      tick();
      checkOutput("rst_cmd",   32'({bus.DM_enable, bus.DM_read, bus.DM_write}), 32'h0);
      checkOutput("rst_addr",  32'(bus.DM_address), 32'h0);
      checkOutput("rst_din",   bus.DM_in, 32'h0);
      checkOutput("rst_acks",  32'({bus.m0_ack, bus.m1_ack}), 32'h0);
      checkOutput("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
      checkOutput("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      reset = 1'b1;
      tick();

      $display("[TB] write then read back through master 0");
      b_issue = issue_cnt; b_wr = wr_cnt;
      runTxn(0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, lat);
      checkOutput("wr_latency", 32'(lat), 32'd5);
      checkOutput("wr_issues",  32'(issue_cnt - b_issue), 32'd1);
      checkOutput("wr_cmds",    32'(wr_cnt - b_wr), 32'd1);
      b_issue = issue_cnt; b_wr = wr_cnt;
      runTxn(0, 1'b1, 1'b0, 12'h010, 32'h0, lat);
      checkOutput("rd_latency", 32'(lat), 32'd5);
      checkOutput("rd_data",    bus.m0_rdata, 32'hDEADBEEF);
      checkOutput("rd_issues",  32'(issue_cnt - b_issue), 32'd1);
      checkOutput("rd_no_wr",   32'(wr_cnt - b_wr), 32'd0);

      runTxn(0, 1'b0, 1'b1, 12'h000, 32'hA0A0A0A0, lat);
      runTxn(0, 1'b0, 1'b1, 12'h004, 32'hB1B1B1B1, lat);

      $display("[TB] master 1 with read and write both set");
      b_wr = wr_cnt; b_ack0 = ack0_cnt;
      runTxn(1, 1'b1, 1'b1, 12'h010, 32'h11111111, lat);
      checkOutput("rw_latency", 32'(lat), 32'd5);
      checkOutput("rw_rdata",   bus.m1_rdata, 32'hDEADBEEF);
      checkOutput("rw_no_wr",   32'(wr_cnt - b_wr), 32'd0);
      checkOutput("rw_no_ack0", 32'(ack0_cnt - b_ack0), 32'd0);

      $display("[TB] simultaneous requests");
      tieTest(12'h000, 12'h004, t0, t1);
      checkOutput("tie1_m0_ack", 32'(t0), 32'd5);
      checkOutput("tie1_m1_ack", 32'(t1), 32'd10);
      checkOutput("tie1_m0_data", bus.m0_rdata, 32'hA0A0A0A0);
      checkOutput("tie1_m1_data", bus.m1_rdata, 32'hB1B1B1B1);
      runTxn(0, 1'b1, 1'b0, 12'h010, 32'h0, lat);
      tieTest(12'h004, 12'h000, t0, t1);
      checkOutput("tie2_m1_ack", 32'(t1), 32'd5);
      checkOutput("tie2_m0_ack", 32'(t0), 32'd10);
      checkOutput("tie2_m0_data", bus.m0_rdata, 32'hB1B1B1B1);
      checkOutput("tie2_m1_data", bus.m1_rdata, 32'hA0A0A0A0);

      $display("[TB] memory not ready for two extra cycles");
      dm_ready_tb = 1'b0; ovr_en = 1'b1; ovr_val = 32'hBAD0BAD0;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 12'h008, 32'h0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 6) begin
            dm_ready_tb = 1'b1;
            ovr_val     = 32'h5A5A5A5A;
         end
         if (bus.m0_ack) begin
            lat = k;
            break;
         end
      end
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h008, 32'h0);
      checkOutput("stall_latency", 32'(lat), 32'd7);
      checkOutput("stall_data",    bus.m0_rdata, 32'h5A5A5A5A);
      ovr_en = 1'b0;
      tick();

      $display("[TB] master 0 request held over three writes");
      b_issue = issue_cnt; b_ack0 = ack0_cnt; b_ack1 = ack1_cnt;
      n = 0; c1 = 0; c2 = 0; c3 = 0;
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 12'h020, 32'hCAFEF00D);
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (bus.m0_ack) begin
            n++;
            if (n == 1) c1 = k;
            if (n == 2) c2 = k;
            if (n == 3) c3 = k;
         end
         if (n == 3) break;
      end
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h020, 32'h0);
      tick(); tick(); tick();
      checkOutput("held_ack1_cycle", 32'(c1), 32'd5);
      checkOutput("held_ack2_cycle", 32'(c2), 32'd11);
      checkOutput("held_ack3_cycle", 32'(c3), 32'd17);
      checkOutput("held_acks",   32'(ack0_cnt - b_ack0), 32'd3);
      checkOutput("held_issues", 32'(issue_cnt - b_issue), 32'd3);
      checkOutput("held_no_m1",  32'(ack1_cnt - b_ack1), 32'd0);

      $display("[TB] reset in the middle of a read");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
      tick(); tick(); tick();
      checkOutput("mid_state_wait", 32'(dut.state_q), 32'(ST_WAIT));
      #2 reset = 1'b0;
      #1;
      checkOutput("mid_rst_cmd",   32'({bus.DM_enable, bus.DM_read, bus.DM_write}), 32'h0);
      checkOutput("mid_rst_addr",  32'(bus.DM_address), 32'h0);
      checkOutput("mid_rst_acks",  32'({bus.m0_ack, bus.m1_ack}), 32'h0);
      checkOutput("mid_rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'h0);
      checkOutput("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0);
      tick(); tick();
      reset = 1'b1;
      b_ack0 = ack0_cnt; b_issue = issue_cnt;
      for (int k = 0; k < 8; k++) tick();
      checkOutput("mid_no_ack",   32'(ack0_cnt - b_ack0), 32'd0);
      checkOutput("mid_no_issue", 32'(issue_cnt - b_issue), 32'd0);

      $display("[TB] priority back to master 0 after reset");
      tieTest(12'h010, 12'h000, t0, t1);
      checkOutput("prio_m0_ack", 32'(t0), 32'd5);
      checkOutput("prio_m1_ack", 32'(t1), 32'd10);
      checkOutput("prio_m0_data", bus.m0_rdata, 32'hDEADBEEF);
      checkOutput("prio_m1_data", bus.m1_rdata, 32'hA0A0A0A0);

      checkOutput("never_both_acks", 32'(both_ack), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter data_size, default 32, data word width.
REQ-002 Parameter mem_size_bit, default 12, byte-address width.
REQ-003 Parameter DM_LATENCY, default 3, clock edges from DM_enable sampled to DM_out valid.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mN_req  input  1  master N (N=0,1) request, held high until mN_ack seen.
REQ-007 mN_read / mN_write  input  1 each  operation select, stable while mN_req high.
REQ-008 mN_address  input  mem_size_bit  byte address, passed to memory unchanged.
REQ-009 mN_wdata  input  data_size  write data.
REQ-010 mN_rdata  output  data_size  read data, valid while mN_ack high, held until next mN read completes.
REQ-011 mN_ack  output  1  one-cycle completion pulse.
REQ-012 DM_enable, DM_read, DM_write  output  1 each  memory command.
REQ-013 DM_address  output  mem_size_bit; DM_in  output  data_size.
REQ-014 DM_out  input  data_size; DM_ready  input  1  memory read data and ready.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; one transaction outstanding at a time.
REQ-016 IDLE: eligible master = mN_req high, (mN_read or mN_write) high, mN_ack low; none eligible -> stay IDLE.
REQ-017 Both eligible -> grant master not granted last (round robin); after reset master 0 has priority.
REQ-018 On grant: latch master id, op, address, wdata; -> ISSUE; both read and write high -> read.
REQ-019 ISSUE (one cycle): DM_enable=1 with DM_read/DM_write per latched op; -> WAIT, counter loaded DM_LATENCY-2.
REQ-020 DM_enable, DM_read, DM_write SHALL be 0 in every state except ISSUE (no repeated commands).
REQ-021 DM_address and DM_in SHALL hold latched values from ISSUE through DONE inclusive (memory uses live DM_in for writes).
REQ-022 WAIT: counter decrements each cycle; counter==0 -> DONE.
REQ-023 DONE, write: -> IDLE, set mN_ack for granted master next cycle.
REQ-024 DONE, read: if DM_ready=1 capture DM_out into mN_rdata, set mN_ack next cycle, -> IDLE; DM_ready=0 -> stay DONE.
REQ-025 Latency read or write, DM_LATENCY=3: req seen in IDLE cycle 0, ISSUE 1, WAIT 2-3, DONE 4, ack cycle 5.
REQ-026 mN_ack never asserted for non-granted master; m0_ack and m1_ack never both high.
REQ-027 Requests arriving outside IDLE wait; not dropped while mN_req held.

Reset
REQ-028 reset low, any state incl. mid-transaction: state=IDLE, all outputs 0, rdata registers 0, priority to master 0, counter 0.
REQ-029 Aborted transaction SHALL not be acked after reset release.

Structure
REQ-030 Package dm_arb_pkg holds state enum, DM_LATENCY default, data_size and mem_size_bit constants.
REQ-031 One sub-module dm_rr_pick: 2-way round-robin grant from eligibility vector and last-grant bit, combinational.

Verification
REQ-032 Reset mid-read (WAIT): reset low -> all outputs 0, state IDLE, no ack after release.
REQ-033 m0 write addr 0x010 data 0xDEADBEEF, then m0 read 0x010 -> DM_enable one cycle each, ack cycle 5, m0_rdata=0xDEADBEEF.
REQ-034 m0 and m1 req same cycle, reads 0x000/0x004 -> m0 first, m1 issued after m0_ack; next tie grants m1 first.
REQ-035 DM_ready held low 2 extra cycles in DONE -> ack delayed 2 cycles, rdata = DM_out when DM_ready rises.
REQ-036 m1_read and m1_write both high -> read issued only, DM_write stays 0.
REQ-037 m0 req held continuously across 3 transactions with m1 idle -> exactly 3 acks, one ISSUE pulse each, no double issue.
